// File: rtl/mem_responder_if.sv
// Core-to-memory request/acknowledge bus for the Frankie data/stack port.
// The core is the master; mem_responder is the slave.
interface mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              err;
    logic              busy;

    modport master (output req, we, addr, wdata, input rdata, ack, err, busy);
    modport slave  (input req, we, addr, wdata, output rdata, ack, err, busy);
endinterface

// File: rtl/mem_responder.sv
// Word-RAM responder with WAIT_CYCLES wait states and a registered one-cycle ack.
// The RAM access happens on the edge entering RESP; ack/err follow one edge later.
module mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 10,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clock,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    localparam int                IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_W:0]   ADDR_LIM  = (ADDR_W+1)'(MEM_WORDS);
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic              enter_resp;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_in_range;
    logic              addr_q_in_range;
    logic [IDX_W-1:0]  acc_idx;

    // With zero wait states the access happens on the accept edge, so it must
    // use the live request fields rather than the (not yet loaded) latches.
    always_comb begin
        acc_we          = (state_q == S_IDLE) ? bus.we    : we_q;
        acc_addr        = (state_q == S_IDLE) ? bus.addr  : addr_q;
        acc_wdata       = (state_q == S_IDLE) ? bus.wdata : wdata_q;
        acc_in_range    = {1'b0, acc_addr} < ADDR_LIM;
        addr_q_in_range = {1'b0, addr_q} < ADDR_LIM;
        acc_idx         = acc_addr[IDX_W-1:0];
        enter_resp      = (state_q == S_IDLE && bus.req && WAIT_CYCLES == 0) ||
                          (state_q == S_WAIT && cnt_q == 4'd1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                busy_d = bus.req;
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP: begin
                // busy stays up through the ack cycle; IDLE drops it afterwards
                busy_d  = 1'b1;
                ack_d   = 1'b1;
                err_d   = !addr_q_in_range;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (enter_resp && !acc_we) rdata_d = acc_in_range ? mem[acc_idx] : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // RAM is never cleared; reset only blocks a write that would land this edge.
    always_ff @(posedge clock) begin
        if (!reset && enter_resp && acc_we && acc_in_range) mem[acc_idx] <= acc_wdata;
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the Frankie core's data and stack accesses.
- The core acts as the initiator: it raises a request with an address, write-enable and write data.
- This block accepts the request, inserts a configurable number of wait states, performs the read or write on its internal word RAM, and returns a one-cycle acknowledge with read data.
- It replaces the zero-latency memory, so the multicycle control unit must be exercised against real wait states.

Parameters:
- DATA_W, 16, word width in bits (matches core register width).
- ADDR_W, 10, word-address width.
- MEM_WORDS, 1024, implemented words. Must satisfy MEM_WORDS <= 2**ADDR_W. Addresses >= MEM_WORDS are out of range.
- WAIT_CYCLES, 2, wait states inserted between acceptance and ack. Legal range 0..15.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request valid from core; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; captured at acceptance.
- addr  in  ADDR_W  word address; captured at acceptance.
- wdata  in  DATA_W  write data; captured at acceptance.
- rdata  out  DATA_W  read data; valid in the ack cycle, held until the next read ack or reset.
- ack  out  1  one-cycle completion pulse.
- err  out  1  asserted with ack when the captured addr >= MEM_WORDS; low otherwise.
- busy  out  1  high from the cycle after acceptance through the ack cycle.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - State goes to IDLE.
  - ack=0, err=0, busy=0, rdata=0, wait counter=0.
  - RAM contents are not cleared.
  - A pending request is discarded: no write occurs and no ack is issued.
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - If req=1 at an edge, latch we/addr/wdata and load the counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else go to RESP.
  - If req=0, stay in IDLE.
- WAIT:
  - Decrement the counter each edge.
  - When the counter reaches 1 at an edge, go to RESP on that edge.
  - req, we, addr and wdata are ignored; changes have no effect.
- RESP:
  - ack=1 for exactly one cycle; err is valid with it.
  - Next state is IDLE.
- Latency:
  - Request sampled at edge N gives ack high during the cycle after edge N+WAIT_CYCLES+1.
  - Exactly WAIT_CYCLES+1 cycles from acceptance to ack.
  - WAIT_CYCLES=0 gives ack in the cycle after acceptance.
- Write:
  - RAM[addr] <= wdata on the edge that enters RESP, only when the address is in range.
  - rdata is unchanged by writes.
- Read:
  - rdata <= RAM[addr] on the edge that enters RESP.
  - Out-of-range read gives rdata=0 with err=1.
- Out of range: addr >= MEM_WORDS gives ack with err=1, no RAM write, no aliasing.
- Back-to-back:
  - State is IDLE in the cycle after ack.
  - If req is still high at that edge, a new request is accepted.
  - The core must drop req after seeing ack unless it issues a new access.
  - Minimum ack spacing is WAIT_CYCLES+2 cycles.
- Read-after-write to the same address returns the newly written value.
- No combinational path from any input to any output; all outputs are registered.
- rdata holds its value through write acks and idle cycles.

Test Plan:
- WAIT_CYCLES=2, MEM_WORDS=512 for all scenarios except 5.
- 1. Write then read:
  - Write 10 to addr 1 (req at edge 0): ack during the cycle after edge 3, err=0.
  - Then read addr 1: rdata=10 with ack 3 cycles after acceptance.
  - busy=1 throughout each access.
- 2. Out of range:
  - Read addr 600: ack with err=1, rdata=0.
  - Write 0x1234 to addr 600: ack with err=1.
  - A subsequent read of addr 88 returns its prior value, showing no aliasing.
- 3. Back-to-back:
  - Hold req=1 with we=1 for addrs 2 then 3 (data 0x00AA, 0x00BB), switching the address on ack.
  - Acks arrive exactly 4 cycles apart.
  - Reads return 0x00AA and 0x00BB.
- 4. Reset mid-access:
  - Write 0x7FFF to addr 5 (previously 0x0003).
  - Assert reset during WAIT: no ack, all outputs 0.
  - A read of addr 5 after reset returns 0x0003.
- 5. Zero wait states:
  - WAIT_CYCLES=0 instance: read of addr 0 (preloaded 0x0002) gives ack the cycle after acceptance, rdata=0x0002.
- 6. Input capture:
  - Request read of addr 4.
  - During WAIT, change addr to 9, we to 1, and drop req.
  - Response returns RAM[4]; RAM[9] is unchanged; exactly one ack is issued.
